// File: rtl/run_detect.sv
// Serial run detector: flags RUN_LEN consecutive equal bits on w with a registered z.
// Optional rising-edge hit counter on z is enabled by defining RUN_DETECT_HITCNT_EN.
module run_detect #(
    parameter int unsigned RUN_LEN  = 4,
    parameter int unsigned DET_MODE = 0
) (
    input  logic        CLK,
    input  logic        res,
    input  logic        w,
    input  logic        en,
    input  logic        clr,
    output logic        z,
    output logic        z_val,
    output logic [7:0]  run_cnt,
    output logic [1:0]  y
`ifdef RUN_DETECT_HITCNT_EN
    ,
    output logic [15:0] hit_cnt
`endif
);

    localparam logic [7:0] LP_LEN = 8'(RUN_LEN);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN0 = 2'b01,
        RUN1 = 2'b10,
        BAD  = 2'b11
    } state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nx;
    logic [7:0] w_cnt_inc;

    // Detection is a pure decode of state and count, so z never sees w combinationally.
    function automatic logic hit_of(input state_t s, input logic [7:0] c);
        logic pol_ok;
        pol_ok = ((s == RUN0) && (DET_MODE != 2)) || ((s == RUN1) && (DET_MODE != 1));
        return pol_ok && (c == LP_LEN);
    endfunction

    assign w_cnt_inc = (r_cnt >= LP_LEN) ? LP_LEN : r_cnt + 8'd1;

    always_ff @(posedge CLK or posedge res) begin
        if (res) begin
            r_state <= IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // The stray code BAD falls through the "not in this run" arms, behaving as IDLE.
    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        if (clr) begin
            w_state_nx = IDLE;
            w_cnt_nx   = 8'd0;
        end else if (en) begin
            if (!w) begin
                if (r_state == RUN0) begin
                    w_cnt_nx = w_cnt_inc;
                end else begin
                    w_state_nx = RUN0;
                    w_cnt_nx   = 8'd1;
                end
            end else begin
                if (r_state == RUN1) begin
                    w_cnt_nx = w_cnt_inc;
                end else begin
                    w_state_nx = RUN1;
                    w_cnt_nx   = 8'd1;
                end
            end
        end
    end

    assign z       = hit_of(r_state, r_cnt);
    assign z_val   = (r_state == RUN1);
    assign run_cnt = r_cnt;
    assign y       = r_state;

`ifdef RUN_DETECT_HITCNT_EN
    logic [15:0] r_hit;

    always_ff @(posedge CLK or posedge res) begin
        if (res) begin
            r_hit <= 16'd0;
        end else if (!z && hit_of(w_state_nx, w_cnt_nx)) begin
            r_hit <= r_hit + 16'd1;
        end
    end

    assign hit_cnt = r_hit;
`endif

endmodule

// File: doc/run_detect.md
RUN_DETECT -- requirements
Module: run_detect

Interface
REQ-001 SHALL have parameter RUN_LEN, default 4, meaning the consecutive equal-bit count that flags a run (legal 2..255).
REQ-002 SHALL have parameter DET_MODE, default 0, meaning the enabled run polarity: 0 = both, 1 = zeros only, 2 = ones only.
REQ-003 SHALL have port CLK  input  1  single clock, rising-edge active.
REQ-004 SHALL have port res  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port w  input  1  serial data bit.
REQ-006 SHALL have port en  input  1  sample enable; w is consumed only on edges where en=1.
REQ-007 SHALL have port clr  input  1  synchronous clear of the run history.
REQ-008 SHALL have port z  output  1  run-detected flag.
REQ-009 SHALL have port z_val  output  1  polarity of the current run (0 = zeros, 1 = ones).
REQ-010 SHALL have port run_cnt  output  8  current run length, saturating at RUN_LEN.
REQ-011 SHALL have port y  output  2  FSM state: 00 IDLE, 01 RUN0, 10 RUN1.

Function
REQ-012 SHALL implement a Moore FSM with states IDLE, RUN0 and RUN1 plus an 8-bit run counter, all registered on CLK.
REQ-013 SHALL, on an edge with en=1 and clr=0 and w=0: if in RUN0, set run_cnt=min(run_cnt+1, RUN_LEN); otherwise go to RUN0 with run_cnt=1.
REQ-014 SHALL, on an edge with en=1 and clr=0 and w=1: if in RUN1, set run_cnt=min(run_cnt+1, RUN_LEN); otherwise go to RUN1 with run_cnt=1.
REQ-015 SHALL hold state and run_cnt on any edge with en=0 and clr=0.
REQ-016 SHALL, on an edge with clr=1, go to IDLE with run_cnt=0, whatever the value of en or w (clr has priority over en).
REQ-017 SHALL set z_val=1 in RUN1 and z_val=0 in RUN0 and IDLE.
REQ-018 SHALL assert z only when run_cnt==RUN_LEN and the state's polarity is enabled by DET_MODE; z is decoded from registers only, with no combinational path from w.
REQ-019 SHALL make z visible in the cycle after the edge that samples the RUN_LEN-th equal bit (one-cycle latency).
REQ-020 SHALL keep z asserted while further equal bits arrive (run_cnt stays saturated at RUN_LEN).
REQ-021 SHALL deassert z in the cycle after the edge that samples an opposite bit; the opposite bit starts a new run with run_cnt=1.
REQ-022 SHALL treat an unreachable state code (11) as IDLE, and the next qualified sample SHALL proceed as from IDLE.

Reset
REQ-023 SHALL, while res=1, force IDLE asynchronously, giving y=00, run_cnt=0, z=0 and z_val=0.
REQ-024 SHALL let reset asserted mid-run discard all run history; after release, RUN_LEN fresh equal bits are needed before z asserts.
REQ-025 SHALL resume sampling on the first CLK rising edge after res deasserts.

Configuration
REQ-026 SHALL, when macro RUN_DETECT_HITCNT_EN is defined, add output port hit_cnt (16 bits), which increments on each edge where z goes from 0 to 1, wraps from 65535 to 0, and is cleared by res but not by clr.
REQ-027 SHALL, when RUN_DETECT_HITCNT_EN is undefined, omit the hit_cnt port and its logic; all other behaviour is identical.

Verification
REQ-028 SHALL cover: RUN_LEN=4, DET_MODE=0, en=1, w=0,0,0,0 -> y=01, run_cnt steps 1..4, z=1 in the cycle after the 4th edge, z_val=0.
REQ-029 SHALL cover: after REQ-028, w=0 for 3 more edges, then w=1 -> z stays 1 with run_cnt=4, then z=0, y=10, run_cnt=1.
REQ-030 SHALL cover: RUN_LEN=4, w=1,1,0,1,1,1,1 -> z=0 until the cycle after the 7th edge, then z=1 with z_val=1.
REQ-031 SHALL cover: DET_MODE=1, w=1 for 6 edges -> run_cnt=4, y=10, z remains 0.
REQ-032 SHALL cover: w=0 for 3 edges, en=0 with w=1 for 2 edges, en=1 with w=0 for 1 edge -> run_cnt=4, z=1; separately, clr=1 and en=1 at run_cnt=3 -> y=00, run_cnt=0.
REQ-033 SHALL cover: res=1 pulsed between edges at run_cnt=4 -> z=0 immediately; with RUN_DETECT_HITCNT_EN defined, hit_cnt=0 after reset and hit_cnt=2 after two separate runs.
